linescanner_axis_packer: RTL

- Parametrised line-scanner-to-AXI-Stream converter.
- Packs strobed pixels of configurable width into AXI_BUS_WIDTH words, frames each scan line with tlast, and buffers words in an internal FIFO so downstream backpressure does not stall capture.
- Sits between the line-scanner pixel capture logic and the AXI-Stream DMA/interconnect in the image capture path.

---
 rtl/linescanner_axis_packer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/linescanner_axis_packer.sv
// Line-scanner pixel packer: packs strobed pixels into AXI-Stream words, frames lines with
// tlast and buffers words in a FWFT FIFO with a registered output stage.
module linescanner_axis_packer #(
    parameter int unsigned AXI_BUS_WIDTH   = 32,
    parameter int unsigned PIXEL_WIDTH     = 8,
    parameter int unsigned PIXELS_PER_LINE = 1024,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                               m00_axis_aclk,
    input  logic                               m00_axis_aresetn,
    input  logic                               enable,
    input  logic [PIXEL_WIDTH-1:0]             input_data,
    input  logic                               pixel_captured,
    input  logic                               m00_axis_tready,
    output logic                               m00_axis_tvalid,
    output logic [AXI_BUS_WIDTH-1:0]           m00_axis_tdata,
    output logic [AXI_BUS_WIDTH/8-1:0]         m00_axis_tstrb,
    output logic                               m00_axis_tlast,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

    localparam int unsigned PPW = AXI_BUS_WIDTH / PIXEL_WIDTH;
    localparam int unsigned BPP = PIXEL_WIDTH / 8;
    localparam int unsigned SW  = AXI_BUS_WIDTH / 8;
    localparam int unsigned LCW = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
    localparam int unsigned WCW = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned MW  = AXI_BUS_WIDTH + SW + 1;

    logic [LCW-1:0]           r_line_cnt;
    logic [WCW-1:0]           r_slot;
    logic [AXI_BUS_WIDTH-1:0] r_word_data;
    logic [SW-1:0]            r_word_strb;

    logic                     r_push_valid;
    logic [MW-1:0]            r_push_word;

    logic [MW-1:0]            r_mem [FIFO_DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [LW-1:0]            r_mem_cnt;
    logic                     r_tvalid;
    logic [AXI_BUS_WIDTH-1:0] r_tdata;
    logic [SW-1:0]            r_tstrb;
    logic                     r_tlast;
    logic                     r_overflow;

    logic                     w_accept;
    logic                     w_line_end;
    logic                     w_word_end;
    logic [AXI_BUS_WIDTH-1:0] w_next_data;
    logic [SW-1:0]            w_next_strb;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_load;
    logic [LW-1:0]            w_level;

    // Capture and packing
    always_comb begin
        w_accept    = enable & pixel_captured;
        w_line_end  = (r_line_cnt == LCW'(PIXELS_PER_LINE - 1));
        w_word_end  = (r_slot == WCW'(PPW - 1)) | w_line_end;
        w_next_data = r_word_data | (AXI_BUS_WIDTH'(input_data) << (PIXEL_WIDTH * r_slot));
        w_next_strb = r_word_strb | (SW'({BPP{1'b1}}) << (BPP * r_slot));
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_line_cnt  <= '0;
            r_slot      <= '0;
            r_word_data <= '0;
            r_word_strb <= '0;
        end else if (!enable) begin
            r_line_cnt  <= '0;
            r_slot      <= '0;
            r_word_data <= '0;
            r_word_strb <= '0;
        end else if (pixel_captured) begin
            r_line_cnt <= w_line_end ? '0 : r_line_cnt + LCW'(1);
            if (w_word_end) begin
                r_slot      <= '0;
                r_word_data <= '0;
                r_word_strb <= '0;
            end else begin
                r_slot      <= r_slot + WCW'(1);
                r_word_data <= w_next_data;
                r_word_strb <= w_next_strb;
            end
        end
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_push_valid <= 1'b0;
            r_push_word  <= '0;
        end else begin
            r_push_valid <= w_accept & w_word_end;
            if (w_accept & w_word_end) begin
                r_push_word <= {w_next_data, w_next_strb, w_line_end};
            end
        end
    end

    // FIFO: level counts memory entries plus the output register
    always_comb begin
        w_pop   = r_tvalid & m00_axis_tready;
        w_level = r_mem_cnt + LW'(r_tvalid);
        w_push  = r_push_valid & ((w_level != LW'(FIFO_DEPTH)) | w_pop);
        w_load  = (r_mem_cnt != '0) & (~r_tvalid | w_pop);
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_push_word;
        end
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tstrb    <= '0;
            r_tlast    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_load) begin
                r_rd_ptr                    <= r_rd_ptr + AW'(1);
                {r_tdata, r_tstrb, r_tlast} <= r_mem[r_rd_ptr];
                r_tvalid                    <= 1'b1;
            end else if (w_pop) begin
                r_tvalid <= 1'b0;
            end
            r_mem_cnt <= r_mem_cnt + LW'(w_push) - LW'(w_load);
            if (r_push_valid & ~w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tdata  = r_tdata;
    assign m00_axis_tstrb  = r_tstrb;
    assign m00_axis_tlast  = r_tlast;
    assign overflow        = r_overflow;
    assign fifo_level      = w_level;

endmodule
